// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clock/strobe generator: channel state encoding
// and the helper that turns a zero phase count into a one-cycle phase.
package clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } chan_state_t;

  function automatic logic [31:0] sat_to_one(input logic [31:0] c);
    return (c == 32'd0) ? 32'd1 : c;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One generator channel: IDLE/HI/LO state machine, phase counter and
// active/pending period registers.
module clk_div_chan
  import clk_gen_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEF_HIGH = 10,
  parameter int DEF_LOW  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] high_cnt,
  input  logic [CNT_W-1:0] low_cnt,
  input  logic             load,
  output logic             clk_out,
  output logic             rise,
  output logic             fall,
  output logic             running
);

  chan_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] act_h, act_h_n, act_l, act_l_n;
  logic [CNT_W-1:0] pend_h, pend_h_n, pend_l, pend_l_n;
  logic             pend_v, pend_v_n;
  logic             rise_n, fall_n;
  logic             h_done, l_done;

  assign h_done = (32'(cnt) >= sat_to_one(32'(act_h)));
  assign l_done = (32'(cnt) >= sat_to_one(32'(act_l)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      act_h   <= CNT_W'(DEF_HIGH);
      act_l   <= CNT_W'(DEF_LOW);
      pend_h  <= '0;
      pend_l  <= '0;
      pend_v  <= 1'b0;
      clk_out <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      act_h   <= act_h_n;
      act_l   <= act_l_n;
      pend_h  <= pend_h_n;
      pend_l  <= pend_l_n;
      pend_v  <= pend_v_n;
      clk_out <= (state_n == HI);
      rise    <= rise_n;
      fall    <= fall_n;
      running <= (state_n != IDLE);
    end
  end

  // Pending values are promoted only in IDLE or at a LO->HI boundary; a LOAD
  // in the same cycle is applied afterwards so it waits for the next boundary.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    act_h_n  = act_h;
    act_l_n  = act_l;
    pend_h_n = pend_h;
    pend_l_n = pend_l;
    pend_v_n = pend_v;
    rise_n   = 1'b0;
    fall_n   = 1'b0;

    case (state)
      IDLE: begin
        if (pend_v) begin
          act_h_n  = pend_h;
          act_l_n  = pend_l;
          pend_v_n = 1'b0;
        end
        if (enable) begin
          state_n = HI;
          cnt_n   = CNT_W'(1);
          rise_n  = 1'b1;
        end
      end
      HI: begin
        if (h_done) begin
          state_n = LO;
          cnt_n   = CNT_W'(1);
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LO: begin
        if (l_done) begin
          if (enable) begin
            state_n = HI;
            cnt_n   = CNT_W'(1);
            rise_n  = 1'b1;
            if (pend_v) begin
              act_h_n  = pend_h;
              act_l_n  = pend_l;
              pend_v_n = 1'b0;
            end
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (load) begin
      pend_h_n = high_cnt;
      pend_l_n = low_cnt;
      pend_v_n = 1'b1;
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel divided clock / strobe generator: one independent
// clk_div_chan per channel, with the packed count buses sliced per channel.
module clk_div_gen
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 8,
  parameter int DEF_HIGH = 10,
  parameter int DEF_LOW  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*CNT_W-1:0] high_cnt,
  input  logic [NUM_CH*CNT_W-1:0] low_cnt,
  input  logic [NUM_CH-1:0]       load,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       rise,
  output logic [NUM_CH-1:0]       fall,
  output logic [NUM_CH-1:0]       running
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_HIGH(DEF_HIGH),
      .DEF_LOW (DEF_LOW)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable[i]),
      .high_cnt(high_cnt[i*CNT_W +: CNT_W]),
      .low_cnt (low_cnt[i*CNT_W +: CNT_W]),
      .load    (load[i]),
      .clk_out (clk_out[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .running (running[i])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: a vector table for the basic waveform plus
// hand-written sequences for reprogramming, stop, reset and channel independence.
module tb_clk_div_gen;

  logic        clk;
  logic        rst;
  logic [1:0]  enable;
  logic [15:0] high_cnt;
  logic [15:0] low_cnt;
  logic [1:0]  load;
  logic [1:0]  clk_out;
  logic [1:0]  rise;
  logic [1:0]  fall;
  logic [1:0]  running;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [1:0] en;
    logic [1:0] ld;
    logic [7:0] h0;
    logic [7:0] l0;
    logic [1:0] out;
    logic [1:0] rs;
    logic [1:0] fl;
    logic [1:0] run;
  } vec_t;

  vec_t vecs[14];

  clk_div_gen #(
    .NUM_CH  (2),
    .CNT_W   (8),
    .DEF_HIGH(10),
    .DEF_LOW (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .high_cnt(high_cnt),
    .low_cnt (low_cnt),
    .load    (load),
    .clk_out (clk_out),
    .rise    (rise),
    .fall    (fall),
    .running (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [1:0] en, input logic [1:0] ld,
                               input logic [7:0] h0, input logic [7:0] l0,
                               input logic [7:0] h1, input logic [7:0] l1);
    rst      = r;
    enable   = en;
    load     = ld;
    high_cnt = {h1, h0};
    low_cnt  = {l1, l0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int ch, input logic eo,
                             input logic er, input logic ef, input logic erun);
    logic [3:0] got, exp;
    got = {clk_out[ch], rise[ch], fall[ch], running[ch]};
    exp = {eo, er, ef, erun};
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s ch%0d: got out/rise/fall/run=%b expected %b at %0t",
               name, ch, got, exp, $time);
    end
  endtask

  // Ticks n cycles on channel 0, expecting clk_out from pat (MSB first); edge
  // strobes follow from consecutive expected levels.
  task automatic expectSeq(input string name, input int n, input logic [31:0] pat,
                           input logic prev, input logic run);
    logic p, e;
    p = prev;
    for (int i = 0; i < n; i++) begin
      tick();
      e = pat[n-1-i];
      checkOutput(name, 0, e, e & ~p, ~e & p, run);
      p = e;
    end
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    tick();
    applyStimulus(1'b0, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
  endtask

  initial begin
    logic [31:0] got_all, exp_all;
    logic        p0, p1, e0, e1, r1;

    vecs[0]  = '{1'b1, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{1'b1, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[2]  = '{1'b0, 2'b00, 2'b01, 8'd2, 8'd3, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[3]  = '{1'b0, 2'b01, 2'b00, 8'd2, 8'd3, 2'b01, 2'b01, 2'b00, 2'b01};
    vecs[4]  = '{1'b0, 2'b01, 2'b00, 8'd2, 8'd3, 2'b01, 2'b00, 2'b00, 2'b01};
    vecs[5]  = '{1'b0, 2'b01, 2'b00, 8'd2, 8'd3, 2'b00, 2'b00, 2'b01, 2'b01};
    vecs[6]  = '{1'b0, 2'b01, 2'b00, 8'd2, 8'd3, 2'b00, 2'b00, 2'b00, 2'b01};
    vecs[7]  = '{1'b0, 2'b01, 2'b00, 8'd2, 8'd3, 2'b00, 2'b00, 2'b00, 2'b01};
    vecs[8]  = '{1'b0, 2'b01, 2'b00, 8'd2, 8'd3, 2'b01, 2'b01, 2'b00, 2'b01};
    vecs[9]  = '{1'b0, 2'b01, 2'b00, 8'd2, 8'd3, 2'b01, 2'b00, 2'b00, 2'b01};
    vecs[10] = '{1'b0, 2'b01, 2'b00, 8'd2, 8'd3, 2'b00, 2'b00, 2'b01, 2'b01};
    vecs[11] = '{1'b0, 2'b01, 2'b00, 8'd2, 8'd3, 2'b00, 2'b00, 2'b00, 2'b01};
    vecs[12] = '{1'b0, 2'b01, 2'b00, 8'd2, 8'd3, 2'b00, 2'b00, 2'b00, 2'b01};
    vecs[13] = '{1'b0, 2'b01, 2'b00, 8'd2, 8'd3, 2'b01, 2'b01, 2'b00, 2'b01};

    applyStimulus(1'b1, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);

    // H=2 L=3 from reset: 1,1,0,0,0 repeating
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].h0, vecs[i].l0, 8'd0, 8'd0);
      tick();
      got_all = {24'd0, clk_out, rise, fall, running};
      exp_all = {24'd0, vecs[i].out, vecs[i].rs, vecs[i].fl, vecs[i].run};
      total++;
      if (got_all !== exp_all) begin
        bad++;
        $display("[TB] FAIL table[%0d]: got out/rise/fall/run=%b expected %b",
                 i, got_all[7:0], exp_all[7:0]);
      end
    end

    // Zero counts behave as one: toggle every cycle
    resetDut();
    checkOutput("after_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 2'b01, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    applyStimulus(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    expectSeq("zero_cnt", 8, 32'b10101010, 1'b0, 1'b1);

    // Mid-period reprogramming, load at a boundary, and last-write-wins
    resetDut();
    applyStimulus(1'b0, 2'b00, 2'b01, 8'd4, 8'd4, 8'd0, 8'd0);
    tick();
    applyStimulus(1'b0, 2'b01, 2'b00, 8'd4, 8'd4, 8'd0, 8'd0);
    expectSeq("reprog_start", 1, 32'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b01, 2'b01, 8'd1, 8'd2, 8'd0, 8'd0);
    expectSeq("reprog_load", 1, 32'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    expectSeq("reprog_apply", 12, 32'b110000100100, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'b01, 2'b01, 8'd3, 8'd1, 8'd0, 8'd0);
    expectSeq("load_at_boundary", 1, 32'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b01, 2'b01, 8'd2, 8'd2, 8'd0, 8'd0);
    expectSeq("load_overwrite", 1, 32'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    expectSeq("last_load_wins", 6, 32'b011001, 1'b0, 1'b1);

    // Enable dropped in the second high cycle: full period, then idle
    resetDut();
    applyStimulus(1'b0, 2'b00, 2'b01, 8'd3, 8'd3, 8'd0, 8'd0);
    tick();
    applyStimulus(1'b0, 2'b01, 2'b00, 8'd3, 8'd3, 8'd0, 8'd0);
    expectSeq("stop_start", 1, 32'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, 2'b00, 8'd3, 8'd3, 8'd0, 8'd0);
    expectSeq("stop_finish", 5, 32'b11000, 1'b1, 1'b1);
    expectSeq("stop_idle", 4, 32'b0000, 1'b0, 1'b0);

    // Reset in the middle of a high phase, then restart on default counts
    resetDut();
    applyStimulus(1'b0, 2'b00, 2'b01, 8'd3, 8'd3, 8'd0, 8'd0);
    tick();
    applyStimulus(1'b0, 2'b01, 2'b00, 8'd3, 8'd3, 8'd0, 8'd0);
    expectSeq("pre_reset", 2, 32'b11, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b01, 2'b00, 8'd3, 8'd3, 8'd0, 8'd0);
    tick();
    checkOutput("mid_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b01, 2'b00, 8'd3, 8'd3, 8'd0, 8'd0);
    expectSeq("default_period", 21, 32'b111111111100000000001, 1'b0, 1'b1);

    // Two independent channels; ch1 disabled mid-period finishes then idles
    resetDut();
    applyStimulus(1'b0, 2'b00, 2'b11, 8'd1, 8'd1, 8'd3, 8'd5);
    tick();
    p0 = 1'b0;
    p1 = 1'b0;
    for (int i = 0; i < 28; i++) begin
      applyStimulus(1'b0, (i <= 16) ? 2'b11 : 2'b01, 2'b00, 8'd1, 8'd1, 8'd3, 8'd5);
      tick();
      e0 = ((i % 2) == 0);
      e1 = (i < 24) && ((i % 8) < 3);
      r1 = (i < 24);
      checkOutput("indep", 0, e0, e0 & ~p0, ~e0 & p0, 1'b1);
      checkOutput("indep", 1, e1, e1 & ~p1, ~e1 & p1, r1);
      p0 = e0;
      p1 = e1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
